fmadd_addnorm_scheduler: RTL and testbench
==========================================

// Module: fmadd_addnorm_scheduler
// PURPOSE
//  Shares one add/sub post-normalization datapath (FMADD_Post_Normalization_Add_Sub) between two requesters:
//  A = FMADD product-add lane, B = FADD/FSUB lane. Round-robin arbitration, one registered issue stage driving
//  the datapath, then a result FIFO with valid/ready backpressure. Output is tagged with the source; sits between
//  mantissa adder and rounding unit.
// PARAMETERS
//  man        22  mantissa MSB index (datapath mantissa width = 2*man+4, result mantissa = man+2)
//  exp        7   exponent MSB index (exponent width = exp+2)
//  RES_DEPTH  2   result FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous active-high reset
//  flush        in   1          sync discard of all in-flight/buffered ops
//  a_valid      in   1          requester A op valid
//  a_ready      out  1          A accepted when a_valid&a_ready
//  a_mantissa   in   2*man+4    A unnormalized sum
//  a_exponent   in   exp+2      A exponent
//  a_flags      in   6          {carry,eff_sub,eff_add,guard,round,sticky}
//  b_valid/b_ready/b_mantissa/b_exponent/b_flags   same as A, for requester B
//  pn_mantissa  out  2*man+4    to datapath mantissa input (registered)
//  pn_exponent  out  exp+2      to datapath exponent input (registered)
//  pn_flags     out  6          to datapath carry/eff/GRS inputs (registered)
//  pn_res_mant  in   man+2      datapath normalized mantissa
//  pn_res_exp   in   exp+2      datapath exponent
//  pn_res_grs   in   3          datapath {guard,round,sticky}
//  res_valid    out  1          result available
//  res_ready    in   1          consumer accepts when res_valid&res_ready
//  res_src      out  1          0=A, 1=B
//  res_mant/res_exp/res_grs  out  man+2/exp+2/3  result fields
// BEHAVIOUR
//  Reset/flush: s1_valid=0, FIFO empty (pointers, count=0), rr_last=1 (A wins first tie), pn_* = 0,
//   res_valid=0, a_ready=b_ready=0 during the rst/flush cycle. Flush drops ops without producing results.
//  Issue stage S1: holds one op {src, mantissa, exponent, flags}; pn_* = S1 contents when s1_valid, else all-zero
//   (eff_add=eff_sub=0 -> datapath idles at zero).
//  S1 advance: s1_adv = s1_valid & (fifo_count<RES_DEPTH | pop). On s1_adv the datapath outputs plus s1_src are
//   written to FIFO at the edge. s1_free = !s1_valid | s1_adv.
//  Arbitration (comb, same cycle): if s1_free: only one valid -> grant it; both valid -> grant !rr_last.
//   x_ready = grant_x & !rst & !flush. rr_last updates to granted source only on accepted handshake.
//   A held request keeps priority ordering; no starvation: each source waits at most one op when both stream.
//  Latency: accept at edge N -> FIFO write at edge N+1 -> res_valid=1 in cycle N+1..N+2 (2 cycles). No bypass.
//  Throughput: 1 op/cycle sustained while res_ready=1.
//  FIFO: pop = res_valid&res_ready; simultaneous push+pop at full legal (count unchanged); pointers wrap at
//   RES_DEPTH; res_* driven from head entry, stable while res_valid&!res_ready.
//  Ordering: results leave in acceptance order across both sources.
//  Flags forwarded unchanged; eff_sub=eff_add=1 not checked (datapath gives eff_sub priority).
//  Width: fifo_count is clog2(RES_DEPTH)+1 bits; never exceeds RES_DEPTH (assert).
// STRUCTURE
//  Package fmadd_pkg: flag bit indices (FLG_CARRY=5..FLG_STICKY=0), SRC_A/SRC_B constants,
//   width localparams MANT_IN_W=2*man+4, MANT_OUT_W=man+2, EXP_W=exp+2.
//  Sub-module fmadd_addnorm_res_fifo (param WIDTH, DEPTH; push/pop/full/empty, sync rst+flush).
//  Datapath instanced outside; this block only sequences it.
// TESTING
//  1 Reset: rst high 2 cycles with a_valid=1 -> a_ready=0, res_valid=0, pn_*=0 throughout.
//  2 Single A op: mant=48'h800000_000000, exp=9'd127, flags=6'b101000, res_ready=1 -> 2 cycles later res_valid,
//   res_src=0, res_mant=24'hC00000, res_exp=9'd128, res_grs=3'b000.
//  3 A and B valid every cycle, res_ready=1 -> grants alternate A,B,A,B; res_src alternates; 1 result/cycle.
//  4 Backpressure: res_ready=0, stream A -> exactly RES_DEPTH+1 accepts (FIFO full + S1), then a_ready=0;
//   release res_ready -> all results in order, none lost/duplicated.
//  5 Flush with FIFO full and S1 valid -> next cycle res_valid=0, no old result appears later; new op completes.
//  6 Random valid/ready on both sides vs scoreboard + datapath model: order, src tags, field values match.

Source files
------------

// File: rtl/fmadd_pkg.sv
// Shared constants for the FMADD add/sub post-normalization scheduler:
// flag bit positions, source tags and datapath width helpers.
package fmadd_pkg;

    // Flag vector layout: {carry, eff_sub, eff_add, guard, round, sticky}
    localparam int FLG_CARRY   = 5;
    localparam int FLG_EFF_SUB = 4;
    localparam int FLG_EFF_ADD = 3;
    localparam int FLG_GUARD   = 2;
    localparam int FLG_ROUND   = 1;
    localparam int FLG_STICKY  = 0;
    localparam int FLAGS_W     = 6;
    localparam int GRS_W       = 3;

    // Source tags carried with every op through S1 and the result FIFO
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Default single-precision-style geometry
    localparam int MAN_DEF    = 22;
    localparam int EXP_DEF    = 7;
    localparam int MANT_IN_W  = 2 * MAN_DEF + 4;
    localparam int MANT_OUT_W = MAN_DEF + 2;
    localparam int EXP_W      = EXP_DEF + 2;

    // Width helpers so parameterised instances derive the same geometry
    function automatic int mant_in_w(input int man);
        return 2 * man + 4;
    endfunction

    function automatic int mant_out_w(input int man);
        return man + 2;
    endfunction

    function automatic int exp_w(input int exp);
        return exp + 2;
    endfunction

endpackage

// File: rtl/fmadd_addnorm_res_fifo.sv
// Result FIFO behind the shared post-normalization datapath. Synchronous
// reset and flush both empty it; push and pop in the same cycle are legal
// even when full, because the pop frees the slot being written.
module fmadd_addnorm_res_fifo
    import fmadd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage
    // NOTE: storage is deliberately not reset; pointers and count define validity, and a resettable array costs a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (rst) count <= (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/fmadd_addnorm_scheduler.sv
// Shares one add/sub post-normalization datapath between the FMADD lane (A)
// and the FADD/FSUB lane (B): round-robin arbitration into a registered issue
// stage that drives the datapath, then a tagged result FIFO with valid/ready.
module fmadd_addnorm_scheduler
    import fmadd_pkg::*;
#(
    parameter int man       = MAN_DEF,
    parameter int exp       = EXP_DEF,
    parameter int RES_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [2*man+3:0]   a_mantissa,
    input  logic [exp+1:0]     a_exponent,
    input  logic [5:0]         a_flags,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [2*man+3:0]   b_mantissa,
    input  logic [exp+1:0]     b_exponent,
    input  logic [5:0]         b_flags,
    output logic [2*man+3:0]   pn_mantissa,
    output logic [exp+1:0]     pn_exponent,
    output logic [5:0]         pn_flags,
    input  logic [man+1:0]     pn_res_mant,
    input  logic [exp+1:0]     pn_res_exp,
    input  logic [2:0]         pn_res_grs,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_src,
    output logic [man+1:0]     res_mant,
    output logic [exp+1:0]     res_exp,
    output logic [2:0]         res_grs
);

    localparam int MIW     = mant_in_w(man);
    localparam int MOW     = mant_out_w(man);
    localparam int EW      = exp_w(exp);
    localparam int ENTRY_W = 1 + MOW + EW + GRS_W;

    // Issue stage contents; cleared to zero when empty so the datapath idles
    logic               s1_valid;
    logic               s1_src;
    logic [MIW-1:0]     s1_mant;
    logic [EW-1:0]      s1_exp;
    logic [FLAGS_W-1:0] s1_flags;
    logic               rr_last;

    logic               pop;
    logic               s1_adv;
    logic               s1_free;
    logic               grant_a;
    logic               grant_b;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign pop     = res_valid & res_ready;
    assign s1_adv  = s1_valid & (~fifo_full | pop);
    assign s1_free = ~s1_valid | s1_adv;

    // On a tie the source that did not win the last accepted handshake goes next
    assign grant_a = s1_free & a_valid & (~b_valid | (rr_last == SRC_B));
    assign grant_b = s1_free & b_valid & (~a_valid | (rr_last == SRC_A));
    assign a_ready = grant_a & ~rst & ~flush;
    assign b_ready = grant_b & ~rst & ~flush;
    assign accept  = a_ready | b_ready;

    // Issue stage register and round-robin history
    // NOTE: non-blocking assignments here so every register samples pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s1_src   <= SRC_A;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_flags <= '0;
            rr_last  <= SRC_B;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_src   <= b_ready ? SRC_B : SRC_A;
            s1_mant  <= b_ready ? b_mantissa : a_mantissa;
            s1_exp   <= b_ready ? b_exponent : a_exponent;
            s1_flags <= b_ready ? b_flags    : a_flags;
            rr_last  <= b_ready ? SRC_B : SRC_A;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
            s1_src   <= SRC_A;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_flags <= '0;
        end
    end

    assign pn_mantissa = s1_mant;
    assign pn_exponent = s1_exp;
    assign pn_flags    = s1_flags;

    assign fifo_wdata = {s1_src, pn_res_mant, pn_res_exp, pn_res_grs};

    fmadd_addnorm_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (s1_adv),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign res_valid = ~fifo_empty & ~rst & ~flush;
    assign {res_src, res_mant, res_exp, res_grs} = fifo_rdata;

endmodule

// File: tb/tb_fmadd_addnorm_scheduler.sv
// Directed and randomised bench for fmadd_addnorm_scheduler with a
// behavioural post-normalization datapath and an in-order scoreboard.
module tb_fmadd_addnorm_scheduler;
    import fmadd_pkg::*;

    localparam int MAN   = 22;
    localparam int EXPM  = 7;
    localparam int DEPTH = 2;
    localparam int MIW   = 48;
    localparam int MOW   = 24;
    localparam int EW    = 9;
    localparam int RW    = 1 + MOW + EW + 3;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           a_valid, a_ready, b_valid, b_ready;
    logic [MIW-1:0] a_mantissa, b_mantissa, pn_mantissa;
    logic [EW-1:0]  a_exponent, b_exponent, pn_exponent;
    logic [5:0]     a_flags, b_flags, pn_flags;
    logic [MOW-1:0] pn_res_mant, res_mant;
    logic [EW-1:0]  pn_res_exp, res_exp;
    logic [2:0]     pn_res_grs, res_grs;
    logic           res_valid, res_ready, res_src;

    int n_checks = 0;
    int n_pass   = 0;
    int n_res    = 0;
    logic [RW-1:0] sb_q[$];

    fmadd_addnorm_scheduler #(
        .man       (MAN),
        .exp       (EXPM),
        .RES_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_mantissa  (a_mantissa),
        .a_exponent  (a_exponent),
        .a_flags     (a_flags),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_mantissa  (b_mantissa),
        .b_exponent  (b_exponent),
        .b_flags     (b_flags),
        .pn_mantissa (pn_mantissa),
        .pn_exponent (pn_exponent),
        .pn_flags    (pn_flags),
        .pn_res_mant (pn_res_mant),
        .pn_res_exp  (pn_res_exp),
        .pn_res_grs  (pn_res_grs),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_src     (res_src),
        .res_mant    (res_mant),
        .res_exp     (res_exp),
        .res_grs     (res_grs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: carry shifts right one place and bumps the exponent,
    // otherwise the top bits are taken as already normalized; idle when no eff op.
    function automatic logic [MOW+EW+2:0] dp_model(input logic [MIW-1:0] m,
                                                   input logic [EW-1:0] e,
                                                   input logic [5:0] f);
        if (!f[FLG_EFF_ADD] && !f[FLG_EFF_SUB]) return '0;
        if (f[FLG_CARRY]) return {1'b1, m[47:25], e + 9'd1, m[24], m[23], |m[22:0]};
        return {m[47:24], e, m[23], m[22], |m[21:0]};
    endfunction

    assign {pn_res_mant, pn_res_exp, pn_res_grs} = dp_model(pn_mantissa, pn_exponent, pn_flags);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: results must leave in acceptance order with matching tag and fields
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0)
                    check("sb_result", 64'({res_src, res_mant, res_exp, res_grs}), 64'(sb_q.pop_front()));
                n_res++;
            end
            if (a_valid && a_ready) sb_q.push_back({SRC_A, dp_model(a_mantissa, a_exponent, a_flags)});
            if (b_valid && b_ready) sb_q.push_back({SRC_B, dp_model(b_mantissa, b_exponent, b_flags)});
        end
    end

    initial begin
        int n_acc;
        int n0;

        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        a_valid = 1'b1; a_mantissa = 48'h800000_000000; a_exponent = 9'd127; a_flags = 6'b101000;
        b_valid = 1'b0; b_mantissa = '0; b_exponent = '0; b_flags = '0;

        // Reset: nothing accepted, no result, datapath inputs idle at zero
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_a_ready", 64'(a_ready), 64'd0);
            check("rst_res_valid", 64'(res_valid), 64'd0);
            check("rst_pn", 64'({pn_mantissa, pn_exponent, pn_flags}), 64'd0);
            next_cycle();
        end

        // Single A op with carry: two-cycle latency, known result fields
        rst = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        check("t2_a_ready", 64'(a_ready), 64'd1);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        check("t2_pn_mant", 64'(pn_mantissa), 64'h800000_000000);
        check("t2_pn_flags", 64'(pn_flags), 64'(6'b101000));
        check("t2_res_valid_early", 64'(res_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t2_res_valid", 64'(res_valid), 64'd1);
        check("t2_res", 64'({res_src, res_mant, res_exp, res_grs}),
              64'({1'b0, 24'hC00000, 9'd128, 3'b000}));
        next_cycle();
        @(negedge clk);
        check("t2_res_drained", 64'(res_valid), 64'd0);
        next_cycle();

        // Both sources streaming: A won last, so B, A, B, A ... one result per cycle
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_mantissa = {8'(i + 1), 40'h00_1234_5678}; a_exponent = 9'(100 + i); a_flags = 6'b001000;
            b_valid = 1'b1; b_mantissa = 48'h9234_5678_9abc ^ 48'(i); b_exponent = 9'(50 + i); b_flags = 6'b110101;
            @(negedge clk);
            check("t3_grant", 64'({a_ready, b_ready}), (i % 2 == 0) ? 64'b01 : 64'b10);
            if (i >= 2) begin
                check("t3_res_valid", 64'(res_valid), 64'd1);
                check("t3_res_src", 64'(res_src), (i % 2 == 0) ? 64'd1 : 64'd0);
            end
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("t3_drained", 64'(sb_q.size()), 64'd0);
        next_cycle();

        // Backpressure: FIFO plus S1 absorb exactly DEPTH+1 ops
        res_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1; a_mantissa = 48'h4000_0000_0000 | 48'(i * 16'h0101); a_exponent = 9'(200 + i); a_flags = 6'b001011;
            @(negedge clk);
            if (a_ready) n_acc++;
            next_cycle();
        end
        @(negedge clk);
        check("t4_accepts", 64'(n_acc), 64'(DEPTH + 1));
        check("t4_stalled", 64'(a_ready), 64'd0);
        next_cycle();
        a_valid = 1'b0; res_ready = 1'b1; n0 = n_res;
        repeat (5) next_cycle();
        @(negedge clk);
        check("t4_released", 64'(n_res - n0), 64'(DEPTH + 1));
        check("t4_drained", 64'(sb_q.size()), 64'd0);
        next_cycle();

        // Flush with FIFO full and S1 valid: everything dropped, new ops restart arbitration
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_mantissa = 48'hFFFF_0000_0000 - 48'(i); a_exponent = 9'd10; a_flags = 6'b010000;
            next_cycle();
        end
        flush = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        check("t5_flush_cycle", 64'({a_ready, b_ready, res_valid}), 64'd0);
        next_cycle();
        flush = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        check("t5_res_valid", 64'(res_valid), 64'd0);
        check("t5_pn_idle", 64'({pn_mantissa, pn_exponent, pn_flags}), 64'd0);
        n0 = n_res;
        next_cycle();
        a_valid = 1'b1; a_mantissa = 48'h0123_4567_89AB; a_exponent = 9'd33; a_flags = 6'b001100;
        b_valid = 1'b1; b_mantissa = 48'hC000_0000_0001; b_exponent = 9'd44; b_flags = 6'b110000;
        @(negedge clk);
        check("t5_tie_after_flush", 64'({a_ready, b_ready}), 64'b10);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        check("t5_b_next", 64'(b_ready), 64'd1);
        next_cycle();
        b_valid = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        check("t5_new_results", 64'(n_res - n0), 64'd2);
        check("t5_drained", 64'(sb_q.size()), 64'd0);
        next_cycle();

        // Random valid/ready on both sides against the scoreboard
        n0 = n_res;
        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1)); b_valid = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 9) < 7);
            a_mantissa = {16'($urandom), $urandom}; a_exponent = 9'($urandom); a_flags = 6'($urandom);
            b_mantissa = {16'($urandom), $urandom}; b_exponent = 9'($urandom); b_flags = 6'($urandom);
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        check("t6_drained", 64'(sb_q.size()), 64'd0);
        check("t6_progress", 64'(n_res - n0 > 100), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
